// File: rtl/lsu_mem_access_pkg.sv
// lsu_mem_access shared types: FSM states, access sizes, fault codes.
package lsu_mem_access_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_FAULT
  } state_t;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_t;

  typedef enum logic [1:0] {
    FLT_NONE,
    FLT_CARRY,
    FLT_ALIGN,
    FLT_TIMEOUT
  } fault_t;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: byte-lane steering for one 64-bit memory word.
// Produces store strobes, lane-shifted store data, extracted and
// zero-extended load data, and the natural-alignment check.
module lsu_lane_align
  import lsu_mem_access_pkg::*;
#(
  parameter int unsigned DATA_W = 64
) (
  input  logic [2:0]          addr_lo,
  input  size_t               size,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   wdata_sh,
  output logic [DATA_W-1:0]   rdata_ext,
  output logic                misalign
);

  logic [5:0]          bit_sh;
  logic [DATA_W/8-1:0] bmask;
  logic [DATA_W-1:0]   dmask;

  assign bit_sh = {addr_lo, 3'b000};

  always_comb begin
    bmask    = '0;
    dmask    = '0;
    misalign = 1'b0;
    unique case (size)
      SZ_B: begin
        bmask = 8'h01;
        dmask = 64'h0000_0000_0000_00FF;
      end
      SZ_H: begin
        bmask    = 8'h03;
        dmask    = 64'h0000_0000_0000_FFFF;
        misalign = addr_lo[0];
      end
      SZ_W: begin
        bmask    = 8'h0F;
        dmask    = 64'h0000_0000_FFFF_FFFF;
        misalign = |addr_lo[1:0];
      end
      SZ_D: begin
        bmask    = '1;
        dmask    = '1;
        misalign = |addr_lo;
      end
    endcase
  end

  assign wstrb     = bmask << addr_lo;
  assign wdata_sh  = wdata << bit_sh;
  assign rdata_ext = (rdata >> bit_sh) & dmask;

endmodule

// File: rtl/lsu_mem_access.sv
// lsu_mem_access: memory-access stage behind the base+imm address adder.
// Optional response timeout: define LSU_TIMEOUT_EN.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned RD_W        = 5,
  parameter int unsigned TIMEOUT_CYC = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [64:0]         req_addr_sum,
  input  logic                req_is_store,
  input  logic [1:0]          req_size,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [RD_W-1:0]     req_rd,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [63:0]         mem_addr,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic [DATA_W-1:0]   wb_data,
  output logic                done,
  output logic                fault_valid,
  output logic [1:0]          fault_code
);

  state_t              state, state_nxt;
  logic [63:0]         addr_q;
  size_t               size_q;
  logic                store_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [RD_W-1:0]     rd_q;
  fault_t              fault_q;

  logic                accept;
  logic                to_hit;
  logic [2:0]          al_addr;
  size_t               al_size;
  logic [DATA_W/8-1:0] al_wstrb;
  logic [DATA_W-1:0]   al_wdata;
  logic [DATA_W-1:0]   al_rdata;
  logic                al_misalign;

  assign accept = req_valid && (state == S_IDLE);

  // One aligner serves both paths: in IDLE it checks the offered request,
  // afterwards it steers the latched operation.
  assign al_addr = (state == S_IDLE) ? req_addr_sum[2:0] : addr_q[2:0];
  assign al_size = (state == S_IDLE) ? size_t'(req_size) : size_q;

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .addr_lo   (al_addr),
    .size      (al_size),
    .wdata     (wdata_q),
    .rdata     (rdata_q),
    .wstrb     (al_wstrb),
    .wdata_sh  (al_wdata),
    .rdata_ext (al_rdata),
    .misalign  (al_misalign)
  );

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != S_WAIT) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign to_hit = (state == S_WAIT) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      size_q  <= SZ_B;
      store_q <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
      rdata_q <= '0;
      fault_q <= FLT_NONE;
    end else begin
      if (accept) begin
        addr_q  <= req_addr_sum[63:0];
        size_q  <= size_t'(req_size);
        store_q <= req_is_store;
        wdata_q <= req_wdata;
        rd_q    <= req_rd;
        if (req_addr_sum[64]) begin
          fault_q <= FLT_CARRY;
        end else if (al_misalign) begin
          fault_q <= FLT_ALIGN;
        end else begin
          fault_q <= FLT_NONE;
        end
      end
      if (state == S_WAIT) begin
        if (mem_rsp_valid) begin
          rdata_q <= mem_rdata;
        end else if (to_hit) begin
          fault_q <= FLT_TIMEOUT;
        end
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_we        = 1'b0;
    mem_wstrb     = '0;
    mem_wdata     = '0;
    wb_valid      = 1'b0;
    wb_rd         = '0;
    wb_data       = '0;
    done          = 1'b0;
    fault_valid   = 1'b0;
    fault_code    = FLT_NONE;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_addr_sum[64] || al_misalign) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        mem_req_valid = 1'b1;
        mem_addr      = {addr_q[63:3], 3'b000};
        mem_we        = store_q;
        if (store_q) begin
          mem_wstrb = al_wstrb;
          mem_wdata = al_wdata;
        end
        if (mem_req_ready) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          state_nxt = S_RESP;
        end else if (to_hit) begin
          state_nxt = S_FAULT;
        end
      end
      S_RESP: begin
        done = 1'b1;
        if (!store_q) begin
          wb_valid = 1'b1;
          wb_rd    = rd_q;
          wb_data  = al_rdata;
        end
        state_nxt = S_IDLE;
      end
      S_FAULT: begin
        done        = 1'b1;
        fault_valid = 1'b1;
        fault_code  = fault_q;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule
